// File: rtl/uart8_pkg.sv
// Shared definitions for the 8N1 UART: state encodings, frame geometry and line levels.
package uart8_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_IDX_W  = $clog2(DATA_BITS);
  localparam int OS_W       = $clog2(OVERSAMPLE);

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [OS_W-1:0]      OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_ERR} rx_state_e;

endpackage

// File: rtl/uart8_baud_rate_gen.sv
// Free-running dividers producing one-cycle bit-rate and 16x oversample tick enables.
module baud_rate_gen
  import uart8_pkg::*;
#(
  parameter int TX_DIV = 1250,
  parameter int RX_DIV = 78
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tx_tick_o,
  output logic rx_tick_o
);

  localparam int TXW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int RXW = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);

  logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RXW-1:0] rx_cnt_q, rx_cnt_d;

  always_comb begin
    tx_cnt_d = (tx_cnt_q == TX_LAST) ? '0 : tx_cnt_q + 1'b1;
    rx_cnt_d = (rx_cnt_q == RX_LAST) ? '0 : rx_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign tx_tick_o = (tx_cnt_q == TX_LAST);
  assign rx_tick_o = (rx_cnt_q == RX_LAST);

endmodule

// File: rtl/uart8_transceiver.sv
// Full-duplex 8N1 UART: bit-rate transmitter and 16x-oversampling receiver on one clock.
module uart8_transceiver
  import uart8_pkg::*;
#(
  parameter int CLOCK_RATE   = 12000000,
  parameter int BAUD_RATE    = 9600,
  parameter int TURBO_FRAMES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxEn,
  input  logic                 rx,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxErr,
  output logic [DATA_BITS-1:0] out,
  input  logic                 txEn,
  input  logic                 txStart,
  input  logic [DATA_BITS-1:0] in,
  output logic                 txBusy,
  output logic                 txDone,
  output logic                 tx
);

  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_DIV = CLOCK_RATE / (OVERSAMPLE * BAUD_RATE);
  localparam int FLAG_W = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam logic [FLAG_W-1:0] FLAG_LAST = FLAG_W'(TX_DIV - 1);

  logic txClk, rxClk;

  baud_rate_gen #(.TX_DIV(TX_DIV), .RX_DIV(RX_DIV)) u_baud (
    .clk_i     (clk),
    .rst_i     (reset),
    .tx_tick_o (txClk),
    .rx_tick_o (rxClk)
  );

  tx_state_e              tx_state_q;
  logic [DATA_BITS-1:0]   tx_shift_q;
  logic [BIT_IDX_W-1:0]   tx_bit_q;
  logic                   tx_q, txBusy_q, txDone_q;

  always_ff @(posedge clk) begin
    if (reset || !txEn) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= STOP_BIT;
      txBusy_q   <= 1'b0;
      txDone_q   <= 1'b0;
      tx_bit_q   <= '0;
    end else if (txClk) begin
      unique case (tx_state_q)
        TX_IDLE, TX_DONE: begin
          txDone_q <= 1'b0;
          if (txStart) begin
            tx_state_q <= TX_START;
            tx_shift_q <= in;
            tx_q       <= START_BIT;
            txBusy_q   <= 1'b1;
          end else begin
            tx_state_q <= TX_IDLE;
            tx_q       <= STOP_BIT;
            txBusy_q   <= 1'b0;
          end
        end
        TX_START: begin
          tx_state_q <= TX_DATA;
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
          tx_bit_q   <= '0;
          txDone_q   <= 1'b0;
        end
        TX_DATA: begin
          if (tx_bit_q == BIT_LAST) begin
            tx_state_q <= TX_STOP;
            tx_q       <= STOP_BIT;
          end else begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= tx_bit_q + 1'b1;
          end
        end
        TX_STOP: begin
          // In turbo mode the done pulse overlaps the next start bit.
          txDone_q <= 1'b1;
          if (txStart && TURBO_FRAMES != 0) begin
            tx_state_q <= TX_START;
            tx_shift_q <= in;
            tx_q       <= START_BIT;
          end else begin
            tx_state_q <= TX_DONE;
            tx_q       <= STOP_BIT;
            txBusy_q   <= 1'b0;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  logic [2:0] rx_sync_q;
  logic       rx_s, rx_fell;

  always_ff @(posedge clk) begin
    if (reset) rx_sync_q <= '1;
    else       rx_sync_q <= {rx_sync_q[1:0], rx};
  end

  assign rx_s    = rx_sync_q[1];
  assign rx_fell = rx_sync_q[2] & ~rx_sync_q[1];

  rx_state_e              rx_state_q;
  logic [DATA_BITS-1:0]   rx_shift_q, out_q;
  logic [BIT_IDX_W-1:0]   rx_bit_q;
  logic [OS_W-1:0]        rx_os_q;
  logic [FLAG_W-1:0]      flag_cnt_q;
  logic                   rxBusy_q, rxDone_q, rxErr_q;

  always_ff @(posedge clk) begin
    if (reset || !rxEn) begin
      rx_state_q <= RX_IDLE;
      rxBusy_q   <= 1'b0;
      rxDone_q   <= 1'b0;
      rxErr_q    <= 1'b0;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      flag_cnt_q <= '0;
      if (reset) out_q <= '0;
    end else begin
      // Flags are timed in system clocks so they span exactly one transmit bit period.
      if (rxDone_q || rxErr_q) begin
        if (flag_cnt_q == FLAG_LAST) begin
          rxDone_q <= 1'b0;
          rxErr_q  <= 1'b0;
        end
        flag_cnt_q <= flag_cnt_q + 1'b1;
      end
      unique case (rx_state_q)
        RX_IDLE: begin
          if (rx_fell) begin
            rx_state_q <= RX_START;
            rxBusy_q   <= 1'b1;
            rx_os_q    <= '0;
          end
        end
        RX_START: begin
          if (rxClk) begin
            if (rx_os_q == OS_MID) begin
              rx_os_q <= '0;
              if (rx_s) begin
                rx_state_q <= RX_IDLE;
                rxBusy_q   <= 1'b0;
              end else begin
                rx_state_q <= RX_DATA;
                rx_bit_q   <= '0;
              end
            end else begin
              rx_os_q <= rx_os_q + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (rxClk) begin
            if (rx_os_q == OS_LAST) begin
              rx_os_q    <= '0;
              rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
              if (rx_bit_q == BIT_LAST) rx_state_q <= RX_STOP;
              else                      rx_bit_q   <= rx_bit_q + 1'b1;
            end else begin
              rx_os_q <= rx_os_q + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (rxClk) begin
            if (rx_os_q == OS_LAST) begin
              rx_os_q    <= '0;
              rxBusy_q   <= 1'b0;
              flag_cnt_q <= '0;
              if (rx_s) begin
                out_q      <= rx_shift_q;
                rxDone_q   <= 1'b1;
                rxErr_q    <= 1'b0;
                rx_state_q <= RX_IDLE;
              end else begin
                rxErr_q    <= 1'b1;
                rxDone_q   <= 1'b0;
                rx_state_q <= RX_ERR;
              end
            end else begin
              rx_os_q <= rx_os_q + 1'b1;
            end
          end
        end
        RX_ERR: begin
          if (rx_s) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign tx     = tx_q;
  assign txBusy = txBusy_q;
  assign txDone = txDone_q;
  assign rxBusy = rxBusy_q;
  assign rxDone = rxDone_q;
  assign rxErr  = rxErr_q;
  assign out    = out_q;

endmodule

// File: tb/tb_uart8_transceiver.sv
// Bench for uart8_transceiver: turbo transmitter looped into the receiver plus directly driven rx frames.
module tb_uart8_transceiver;

  localparam int CLK_RATE = 320;
  localparam int BAUD     = 10;
  localparam int BIT_CYC  = CLK_RATE / BAUD;
  localparam logic [7:0] STREAM [20] = '{8'd30, 8'd24, 8'd19, 8'd25, 8'd91, 8'd77, 8'd1, 8'd0, 8'd99, 8'd15,
                                         8'd100, 8'd128, 8'd255, 8'd254, 8'd0, 8'd10, 8'd43, 8'd149, 8'd7, 8'd2};

  logic       clk = 1'b0;
  logic       reset, rxEn, rx, rxBusy, rxDone, rxErr;
  logic       txEn, txStart, txBusy, txDone, tx;
  logic [7:0] out, tx_byte;
  logic       rx_drv, loop_en;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart8_transceiver #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .TURBO_FRAMES(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .rxEn    (rxEn),
    .rx      (rx),
    .rxBusy  (rxBusy),
    .rxDone  (rxDone),
    .rxErr   (rxErr),
    .out     (out),
    .txEn    (txEn),
    .txStart (txStart),
    .in      (tx_byte),
    .txBusy  (txBusy),
    .txDone  (txDone),
    .tx      (tx)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb [$];
  int         rx_done_cnt = 0;
  int         rx_err_cnt = 0;
  int         err_hi_cyc = 0;
  logic       done_prev = 1'b0;
  logic       err_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receive-side monitor: every rxDone rising edge pops one expected byte.
  always @(negedge clk) begin
    if (rxErr) err_hi_cyc++;
    if (rxErr && !err_prev) rx_err_cnt++;
    if (rxDone && !done_prev) begin
      rx_done_cnt++;
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check_eq("rx_byte", 32'(out), 32'(sb.pop_front()));
    end
    done_prev = rxDone;
    err_prev  = rxErr;
  end

  task automatic wait_tx_busy(input string tag);
    int n = 0;
    while (!txBusy && n < 2 * BIT_CYC) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(txBusy), 32'd1);
  endtask

  task automatic wait_tx_done_rise(output bit ok);
    int n = 0;
    while (txDone && n < 12 * BIT_CYC) begin
      @(negedge clk);
      n++;
    end
    while (!txDone && n < 12 * BIT_CYC) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 12 * BIT_CYC);
  endtask

  task automatic wait_rx_count(input int target, input string tag);
    int n = 0;
    while (rx_done_cnt < target && n < 16 * BIT_CYC) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(rx_done_cnt), 32'(target));
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_lvl);
    rx_drv = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx_drv = stop_lvl;
    repeat (BIT_CYC) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    bit         ok;
    int         d0, e0, h0;

    reset = 1'b1; rxEn = 1'b1; txEn = 1'b1; txStart = 1'b0;
    tx_byte = 8'h00; rx_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_txBusy", 32'(txBusy), 32'd0);
    check_eq("rst_txDone", 32'(txDone), 32'd0);
    check_eq("rst_rxBusy", 32'(rxBusy), 32'd0);
    check_eq("rst_rxDone", 32'(rxDone), 32'd0);
    check_eq("rst_rxErr", 32'(rxErr), 32'd0);
    check_eq("rst_out", 32'(out), 32'h00);
    reset = 1'b0;
    repeat (2 * BIT_CYC) @(negedge clk);

    // Single frame 0x1E with a pulsed request, sampled at each bit midpoint.
    tx_byte = 8'h1E; txStart = 1'b1;
    wait_tx_busy("f1e_busy");
    txStart = 1'b0;
    repeat (BIT_CYC / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      bits[k] = tx;
      repeat (BIT_CYC) @(negedge clk);
    end
    check_eq("f1e_bits", 32'(bits), 32'(10'b1000111100));
    check_eq("f1e_done", 32'(txDone), 32'd1);
    check_eq("f1e_busy_low", 32'(txBusy), 32'd0);
    repeat (BIT_CYC) @(negedge clk);
    check_eq("f1e_done_end", 32'(txDone), 32'd0);
    check_eq("f1e_idle_tx", 32'(tx), 32'd1);

    // Streaming loopback with the request held high.
    loop_en = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    d0 = rx_done_cnt;
    tx_byte = STREAM[0]; sb.push_back(STREAM[0]); txStart = 1'b1;
    wait_tx_busy("lb_busy");
    for (int k = 1; k < 20; k++) begin
      tx_byte = STREAM[k];
      sb.push_back(STREAM[k]);
      wait_tx_done_rise(ok);
      check_eq("lb_latch", 32'(ok), 32'd1);
    end
    txStart = 1'b0;
    wait_rx_count(d0 + 20, "lb_count");
    check_eq("lb_no_err", 32'(rx_err_cnt), 32'd0);
    check_eq("lb_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of a 0xA5 frame.
    repeat (2 * BIT_CYC) @(negedge clk);
    tx_byte = 8'hA5; txStart = 1'b1;
    wait_tx_busy("mid_busy");
    repeat (5 * BIT_CYC) @(negedge clk);
    check_eq("mid_rx_active", 32'(rxBusy), 32'd1);
    reset = 1'b1; txStart = 1'b0;
    @(negedge clk);
    check_eq("mid_tx", 32'(tx), 32'd1);
    check_eq("mid_txBusy", 32'(txBusy), 32'd0);
    check_eq("mid_txDone", 32'(txDone), 32'd0);
    check_eq("mid_rxBusy", 32'(rxBusy), 32'd0);
    check_eq("mid_rxDone", 32'(rxDone), 32'd0);
    check_eq("mid_rxErr", 32'(rxErr), 32'd0);
    check_eq("mid_out", 32'(out), 32'h00);
    loop_en = 1'b0;
    reset = 1'b0;
    repeat (2 * BIT_CYC) @(negedge clk);

    // Good frame, then 0x55 with its stop bit held low.
    sb.push_back(8'hC3);
    drive_rx_frame(8'hC3, 1'b1);
    repeat (2 * BIT_CYC) @(negedge clk);
    d0 = rx_done_cnt; e0 = rx_err_cnt; h0 = err_hi_cyc;
    drive_rx_frame(8'h55, 1'b0);
    repeat (2 * BIT_CYC) @(negedge clk);
    check_eq("err_count", 32'(rx_err_cnt), 32'(e0 + 1));
    check_eq("err_width", 32'(err_hi_cyc), 32'(h0 + BIT_CYC));
    check_eq("err_no_done", 32'(rx_done_cnt), 32'(d0));
    check_eq("err_out_kept", 32'(out), 32'hC3);
    check_eq("err_sb_empty", 32'(sb.size()), 32'd0);

    // Short low glitch on an idle line.
    d0 = rx_done_cnt; e0 = rx_err_cnt;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("glitch_start", 32'(rxBusy), 32'd1);
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BIT_CYC + 8) @(negedge clk);
    check_eq("glitch_busy", 32'(rxBusy), 32'd0);
    check_eq("glitch_done", 32'(rx_done_cnt), 32'(d0));
    check_eq("glitch_err", 32'(rx_err_cnt), 32'(e0));

    // Transmitter disabled during a data bit, then re-enabled.
    tx_byte = 8'h3C; txStart = 1'b1;
    wait_tx_busy("abort_busy");
    txStart = 1'b0;
    repeat (2 * BIT_CYC + BIT_CYC / 2) @(negedge clk);
    check_eq("abort_pre_tx", 32'(tx), 32'd0);
    txEn = 1'b0;
    @(negedge clk);
    check_eq("abort_tx", 32'(tx), 32'd1);
    check_eq("abort_txBusy", 32'(txBusy), 32'd0);
    repeat (2 * BIT_CYC) @(negedge clk);
    check_eq("abort_hold_tx", 32'(tx), 32'd1);
    check_eq("abort_hold_busy", 32'(txBusy), 32'd0);
    txEn = 1'b1; loop_en = 1'b1;
    d0 = rx_done_cnt;
    sb.push_back(8'h81);
    tx_byte = 8'h81; txStart = 1'b1;
    wait_tx_busy("reen_busy");
    txStart = 1'b0;
    wait_rx_count(d0 + 1, "reen_count");
    check_eq("reen_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("reen_no_err", 32'(rx_err_cnt), 32'(e0));

    repeat (BIT_CYC) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
